// File: rtl/pwm_pkg.sv
// Shared constants for the PWM mixer: default parameters and derived
// mix/compare widths.
package pwm_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_OUT_W    = 8;
  localparam int DEF_GAIN_W   = 4;

  // Width that holds the sum of num_ch full-scale samples without overflow.
  function automatic int sum_width(input int sample_w, input int num_ch);
    return sample_w + $clog2(num_ch);
  endfunction

  localparam int DEF_SUM_W = sum_width(DEF_SAMPLE_W, DEF_NUM_CH);
  localparam int DEF_CMP_W = DEF_OUT_W + 1;

endpackage

// File: rtl/pwm_core.sv
// PWM counter and comparator with period/duty double-buffering; new period
// and compare values only take effect at a period boundary.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [OUT_W-1:0] i_top,
  input  logic             i_top_valid,
  input  logic [OUT_W:0]   i_cmp,
  input  logic             i_clip,
  output logic [OUT_W-1:0] o_active_top,
  output logic             o_pwm,
  output logic             o_pwm_n,
  output logic             o_cycle_end,
  output logic             o_clip
);

  logic [OUT_W-1:0] cnt, cnt_nxt;
  logic [OUT_W-1:0] active_top, top_nxt;
  logic [OUT_W-1:0] pending_top, ptop_nxt;
  logic             pending, pend_nxt;
  logic [OUT_W:0]   active_cmp, cmp_nxt;
  logic             active_clip, clip_nxt;
  logic             wrap;
  logic             pwm_nxt;

  // Outputs are registered from next-state values so they line up with the
  // counter: o_cycle_end marks counter == active_top on the same clock.
  always_comb begin
    wrap     = (cnt == active_top);
    cnt_nxt  = wrap ? '0 : cnt + 1'b1;
    top_nxt  = active_top;
    cmp_nxt  = active_cmp;
    clip_nxt = active_clip;
    ptop_nxt = pending_top;
    pend_nxt = pending;
    if (i_top_valid) begin
      ptop_nxt = i_top;
      pend_nxt = 1'b1;
    end
    if (wrap) begin
      cmp_nxt  = i_cmp;
      clip_nxt = i_clip;
      if (pend_nxt) begin
        top_nxt  = ptop_nxt;
        pend_nxt = 1'b0;
      end
    end
    pwm_nxt = ({1'b0, cnt_nxt} < cmp_nxt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt         <= '0;
      active_top  <= '1;
      pending_top <= '1;
      pending     <= 1'b0;
      active_cmp  <= '0;
      active_clip <= 1'b0;
      o_pwm       <= 1'b0;
      o_pwm_n     <= 1'b1;
      o_cycle_end <= 1'b0;
      o_clip      <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      active_top  <= top_nxt;
      pending_top <= ptop_nxt;
      pending     <= pend_nxt;
      active_cmp  <= cmp_nxt;
      active_clip <= clip_nxt;
      o_pwm       <= pwm_nxt;
      o_pwm_n     <= ~pwm_nxt;
      o_cycle_end <= (cnt_nxt == top_nxt);
      o_clip      <= clip_nxt;
    end
  end

  assign o_active_top = active_top;

endmodule

// File: rtl/pwm_mixer.sv
// Multi-channel sample mixer: per-channel gain/mute scaling, summing and
// clamping to the active PWM period, driving a double-buffered PWM core.
module pwm_mixer
  import pwm_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int GAIN_W   = DEF_GAIN_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0] i_samples,
  input  logic [NUM_CH-1:0]          i_sample_valid,
  input  logic [NUM_CH*GAIN_W-1:0]   i_gain,
  input  logic [NUM_CH-1:0]          i_mute,
  input  logic [OUT_W-1:0]           i_top,
  input  logic                       i_top_valid,
  output logic                       o_pwm,
  output logic                       o_pwm_n,
  output logic                       o_cycle_end,
  output logic                       o_clip
);

  localparam int SUM_W  = sum_width(SAMPLE_W, NUM_CH);
  localparam int CMP_W  = OUT_W + 1;
  localparam int EXT_W  = (SUM_W > CMP_W) ? SUM_W : CMP_W;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  // Gain code g multiplies by (g+1)/2^GAIN_W, so the top code is unity.
  function automatic logic [SAMPLE_W-1:0] scale(input logic [SAMPLE_W-1:0] s,
                                                input logic [GAIN_W-1:0]   g);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(s) * (PROD_W'(g) + PROD_W'(1));
    return prod[GAIN_W +: SAMPLE_W];
  endfunction

  // Returns {clip, cmp}: mix clamped to one full period of high time.
  function automatic logic [CMP_W:0] saturate(input logic [SUM_W-1:0] mix,
                                              input logic [OUT_W-1:0] top);
    logic [EXT_W-1:0] m, lim;
    m   = EXT_W'(mix);
    lim = EXT_W'(top) + EXT_W'(1);
    if (m > lim) return {1'b1, CMP_W'(lim)};
    else         return {1'b0, CMP_W'(m)};
  endfunction

  logic [SAMPLE_W-1:0] sample_p0 [NUM_CH];
  logic [SAMPLE_W-1:0] scaled_p1 [NUM_CH];
  logic [SUM_W-1:0]    mix_sum;
  logic [CMP_W-1:0]    cmp_p2;
  logic                clip_p2;
  logic [OUT_W-1:0]    active_top;

  always_comb begin
    mix_sum = '0;
    for (int k = 0; k < NUM_CH; k++) mix_sum = mix_sum + SUM_W'(scaled_p1[k]);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        sample_p0[k] <= '0;
        scaled_p1[k] <= '0;
      end
      cmp_p2  <= '0;
      clip_p2 <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        // Stage p0: per-channel sample hold
        if (i_sample_valid[k]) sample_p0[k] <= i_samples[k*SAMPLE_W +: SAMPLE_W];
        // Stage p1: gain and mute
        scaled_p1[k] <= i_mute[k] ? '0 : scale(sample_p0[k], i_gain[k*GAIN_W +: GAIN_W]);
      end
      // Stage p2: channel sum clamped against the running period
      {clip_p2, cmp_p2} <= saturate(mix_sum, active_top);
    end
  end

  pwm_core #(
    .OUT_W(OUT_W)
  ) u_core (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_top        (i_top),
    .i_top_valid  (i_top_valid),
    .i_cmp        (cmp_p2),
    .i_clip       (clip_p2),
    .o_active_top (active_top),
    .o_pwm        (o_pwm),
    .o_pwm_n      (o_pwm_n),
    .o_cycle_end  (o_cycle_end),
    .o_clip       (o_clip)
  );

endmodule

// File: tb/tb_pwm_mixer.sv
// Self-checking bench for pwm_mixer: randomized channel settings compared
// against an arithmetic model of the mixed duty cycle and period.
module tb_pwm_mixer;

  localparam int NUM_CH = 4, SAMPLE_W = 8, OUT_W = 8, GAIN_W = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_CH*SAMPLE_W-1:0] samples;
  logic [NUM_CH-1:0]          sample_valid;
  logic [NUM_CH*GAIN_W-1:0]   gain;
  logic [NUM_CH-1:0]          mute;
  logic [OUT_W-1:0]           top;
  logic                       top_valid;
  logic                       pwm, pwm_n, cycle_end, clip;

  int checks = 0;
  int passed = 0;

  int ch_val  [NUM_CH];
  int ch_gain [NUM_CH];
  bit ch_mute [NUM_CH];
  int cur_top = 255;

  always #5 clk = ~clk;

  pwm_mixer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_samples      (samples),
    .i_sample_valid (sample_valid),
    .i_gain         (gain),
    .i_mute         (mute),
    .i_top          (top),
    .i_top_valid    (top_valid),
    .o_pwm          (pwm),
    .o_pwm_n        (pwm_n),
    .o_cycle_end    (cycle_end),
    .o_clip         (clip)
  );

  // Reference: total of the scaled, unmuted channels.
  function automatic int model_mix();
    int s = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (!ch_mute[k]) s += (ch_val[k] * (ch_gain[k] + 1)) / (1 << GAIN_W);
    return s;
  endfunction

  function automatic int model_high(input int mix, input int t);
    return (mix > t + 1) ? t + 1 : mix;
  endfunction

  task automatic apply_channels();
    @(posedge clk); #1;
    for (int k = 0; k < NUM_CH; k++) begin
      samples[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(ch_val[k]);
      gain[k*GAIN_W +: GAIN_W]        = GAIN_W'(ch_gain[k]);
      mute[k]                         = ch_mute[k];
    end
    sample_valid = '1;
    @(posedge clk); #1;
    sample_valid = '0;
  endtask

  task automatic wait_end();
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (cycle_end === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) $display("FAIL wait_cycle_end: no o_cycle_end within 600 clocks (required one)");
    else passed++;
  endtask

  task automatic settle();
    wait_end();
    wait_end();
  endtask

  // Observes one period starting right after an o_cycle_end clock.
  task automatic measure(input int pulse_at, input int pulse_top,
                         output int len, output int high,
                         output bit shape_ok, output logic clip_seen);
    bit seen_low = 0;
    len = 0; high = 0; shape_ok = 1; clip_seen = 1'bx;
    forever begin
      @(posedge clk); #1;
      len++;
      if (len == pulse_at) begin top = OUT_W'(pulse_top); top_valid = 1'b1; end
      else top_valid = 1'b0;
      if (pwm_n !== ~pwm) shape_ok = 0;
      if (pwm === 1'b1) begin high++; if (seen_low) shape_ok = 0; end
      else seen_low = 1;
      if (len == 1) clip_seen = clip;
      else if (clip !== clip_seen) shape_ok = 0;
      if (cycle_end === 1'b1) break;
      if (len >= 600) begin len = -1; break; end
    end
  endtask

  task automatic count_first_end(output int idx);
    idx = 1;
    while (idx < 600) begin
      @(posedge clk); #1;
      idx++;
      if (cycle_end === 1'b1) break;
    end
  endtask

  task automatic check_duty(input string name);
    int len, high, mix;
    bit shape_ok;
    logic c;
    mix = model_mix();
    measure(0, 0, len, high, shape_ok, c);
    checks++;
    if (len !== cur_top + 1) $display("FAIL %s_len: got %0d need %0d", name, len, cur_top + 1);
    else passed++;
    checks++;
    if (high !== model_high(mix, cur_top))
      $display("FAIL %s_high: got %0d need %0d", name, high, model_high(mix, cur_top));
    else passed++;
    checks++;
    if (c !== logic'(mix > cur_top + 1)) $display("FAIL %s_clip: got %b need %b", name, c, mix > cur_top + 1);
    else passed++;
    checks++;
    if (shape_ok !== 1'b1) $display("FAIL %s_shape: got %b need 1", name, shape_ok);
    else passed++;
  endtask

  task automatic test_reset();
    int idx;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (pwm !== 1'b0) $display("FAIL reset_pwm: got %b need 0", pwm); else passed++;
    checks++; if (pwm_n !== 1'b1) $display("FAIL reset_pwm_n: got %b need 1", pwm_n); else passed++;
    checks++; if (cycle_end !== 1'b0) $display("FAIL reset_cycle_end: got %b need 0", cycle_end); else passed++;
    checks++; if (clip !== 1'b0) $display("FAIL reset_clip: got %b need 0", clip); else passed++;
    rst_n = 1'b1;
    count_first_end(idx);
    checks++;
    if (idx !== 256) $display("FAIL reset_first_end: got clock %0d need 256", idx); else passed++;
  endtask

  task automatic test_unity();
    for (int k = 0; k < NUM_CH; k++) begin ch_val[k] = 0; ch_gain[k] = 15; ch_mute[k] = 1; end
    ch_val[0] = 128; ch_mute[0] = 0;
    apply_channels();
    settle();
    check_duty("unity");
  endtask

  task automatic test_gain();
    ch_val[0] = 255; ch_gain[0] = 7;
    apply_channels();
    settle();
    check_duty("gain");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < NUM_CH; k++) begin ch_val[k] = 200; ch_gain[k] = 15; ch_mute[k] = 0; end
    apply_channels();
    settle();
    check_duty("saturation");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        ch_val[k]  = int'($urandom_range(0, 255));
        ch_gain[k] = int'($urandom_range(0, 15));
        ch_mute[k] = ($urandom_range(0, 3) == 0);
      end
      apply_channels();
      settle();
      check_duty("random");
    end
  endtask

  task automatic test_period_change();
    int len, high;
    bit shape_ok;
    logic c;
    for (int k = 0; k < NUM_CH; k++) begin ch_val[k] = 0; ch_gain[k] = 15; ch_mute[k] = 1; end
    ch_val[0] = 128; ch_mute[0] = 0;
    apply_channels();
    settle();
    measure(51, 99, len, high, shape_ok, c);
    checks++; if (len !== 256) $display("FAIL period_current_len: got %0d need 256", len); else passed++;
    cur_top = 99;
    measure(0, 0, len, high, shape_ok, c);
    checks++; if (len !== 100) $display("FAIL period_new_len: got %0d need 100", len); else passed++;
    // Steady at top 99; pulse top 255 on this period's final clock.
    measure(100, 255, len, high, shape_ok, c);
    checks++; if (len !== 100) $display("FAIL period_steady_len: got %0d need 100", len); else passed++;
    checks++; if (high !== 100) $display("FAIL period_steady_high: got %0d need 100", high); else passed++;
    checks++; if (c !== 1'b1) $display("FAIL period_steady_clip: got %b need 1", c); else passed++;
    cur_top = 255;
    measure(0, 0, len, high, shape_ok, c);
    checks++; if (len !== 256) $display("FAIL period_coincide_len: got %0d need 256", len); else passed++;
    check_duty("period_restored");
  endtask

  task automatic test_top_zero();
    int ce_cnt = 0, hi_cnt = 0, lo_cnt = 0, len, high;
    bit shape_ok;
    logic c;
    @(posedge clk); #1;
    top = '0; top_valid = 1'b1;
    @(posedge clk); #1;
    top_valid = 1'b0;
    wait_end();
    repeat (4) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cycle_end === 1'b1) ce_cnt++;
      if (pwm === 1'b1) hi_cnt++;
    end
    checks++; if (ce_cnt !== 8) $display("FAIL top0_cycle_end: got %0d of 8 need 8", ce_cnt); else passed++;
    checks++; if (hi_cnt !== 8) $display("FAIL top0_pwm_high: got %0d of 8 need 8", hi_cnt); else passed++;
    checks++; if (clip !== 1'b1) $display("FAIL top0_clip: got %b need 1", clip); else passed++;
    ch_mute[0] = 1;
    apply_channels();
    repeat (5) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (pwm === 1'b0 && pwm_n === 1'b1) lo_cnt++;
    end
    checks++; if (lo_cnt !== 6) $display("FAIL top0_pwm_low: got %0d of 6 need 6", lo_cnt); else passed++;
    ch_mute[0] = 0;
    apply_channels();
    top = OUT_W'(255); top_valid = 1'b1;
    @(posedge clk); #1;
    top_valid = 1'b0;
    wait_end();
    measure(0, 0, len, high, shape_ok, c);
    checks++; if (len !== 256) $display("FAIL top0_restore_len: got %0d need 256", len); else passed++;
  endtask

  task automatic test_midop_reset();
    int idx;
    wait_end();
    repeat (10) @(posedge clk);
    #1;
    checks++; if (pwm !== 1'b1) $display("FAIL midrst_pwm_before: got %b need 1", pwm); else passed++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (pwm !== 1'b0) $display("FAIL midrst_pwm: got %b need 0", pwm); else passed++;
    checks++; if (pwm_n !== 1'b1) $display("FAIL midrst_pwm_n: got %b need 1", pwm_n); else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur_top = 255;
    count_first_end(idx);
    checks++; if (idx !== 256) $display("FAIL midrst_first_end: got clock %0d need 256", idx); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; samples = '0; sample_valid = '0; gain = '0; mute = '0;
    top = '0; top_valid = 1'b0;
    test_reset();
    test_unity();
    test_gain();
    test_saturation();
    test_random();
    test_period_change();
    test_top_zero();
    test_midop_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pwm_mixer.md
PWM_MIXER -- requirements
Module: pwm_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of mixer channels (1..8).
REQ-002 SHALL have parameter SAMPLE_W, default 8, width of each channel sample.
REQ-003 SHALL have parameter OUT_W, default 8, width of the PWM counter and period register.
REQ-004 SHALL have parameter GAIN_W, default 4, width of each channel gain.
REQ-005 SHALL have port i_clk, input, 1, the single clock.
REQ-006 SHALL have port i_rst_n, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port i_samples, input, NUM_CH*SAMPLE_W, unsigned channel samples, ch0 in LSBs.
REQ-008 SHALL have port i_sample_valid, input, NUM_CH, per-channel sample strobe.
REQ-009 SHALL have port i_gain, input, NUM_CH*GAIN_W, per-channel gain code.
REQ-010 SHALL have port i_mute, input, NUM_CH, per-channel mute.
REQ-011 SHALL have port i_top, input, OUT_W, requested PWM period minus one.
REQ-012 SHALL have port i_top_valid, input, 1, strobe capturing i_top as the pending period.
REQ-013 SHALL have port o_pwm, output, 1, PWM output.
REQ-014 SHALL have port o_pwm_n, output, 1, complement of o_pwm.
REQ-015 SHALL have port o_cycle_end, output, 1, one-clock pulse on the last clock of each PWM period.
REQ-016 SHALL have port o_clip, output, 1, high for the whole PWM period whose compare value was clamped.

Function
REQ-017 Each channel SHALL hold its sample in a register, loaded only on the clock its i_sample_valid bit is high.
REQ-018 Stage 1 SHALL register scaled_k = (sample_k * (gain_k + 1)) >> GAIN_W, or 0 when i_mute[k] is high; gain code 2^GAIN_W-1 is unity.
REQ-019 Stage 2 SHALL register mix = sum of all scaled_k at width SAMPLE_W + clog2(NUM_CH), with no overflow.
REQ-020 Stage 2 SHALL also register cmp = min(mix, active_top + 1) at width OUT_W+1, plus a clip flag set when mix > active_top + 1.
REQ-021 Sample-to-cmp latency SHALL be 3 clocks: sample register, then stage 1, then stage 2.
REQ-022 The counter SHALL count 0..active_top, then wrap to 0.
REQ-023 o_pwm SHALL be registered and equal (counter < active_cmp): cmp 0 gives always low, cmp active_top+1 gives always high.
REQ-024 o_cycle_end SHALL be high exactly on the clock where counter == active_top.
REQ-025 On the clock o_cycle_end is high, active_cmp and active_clip SHALL load from stage 2, and active_top SHALL load from pending_top if a pending flag is set, which then clears.
REQ-026 The new values from REQ-025 SHALL apply from counter 0 of the next period; no mid-period change to duty or period.
REQ-027 i_top_valid SHALL set pending_top and the pending flag; a later strobe before the boundary overwrites it.
REQ-028 If i_top_valid coincides with o_cycle_end, the new i_top SHALL take effect at that boundary.
REQ-029 active_top = 0 SHALL give a 1-clock period with o_cycle_end held high; o_pwm follows cmp (0 or 1).
REQ-030 o_pwm_n SHALL be the registered inverse of o_pwm; o_clip SHALL equal active_clip.

Reset
REQ-031 While i_rst_n is low at a rising edge, the following SHALL be cleared to 0: sample registers, stage registers, counter, active_cmp, active_clip, pending flag, o_pwm, o_cycle_end, o_clip.
REQ-032 On the same condition, active_top and pending_top SHALL load all-ones, and o_pwm_n SHALL be 1.
REQ-033 Reset asserted mid-period SHALL take effect on the next edge with no completion of the current period.

Structure
REQ-034 Package pwm_pkg SHALL hold default parameter constants and the clog2-derived sum-width and compare-width constants.
REQ-035 The counter/comparator/double-buffer SHALL be sub-module pwm_core (ports i_clk, i_rst_n, i_top, i_top_valid, i_cmp, i_clip, outputs).
REQ-036 Channel scaling and summing SHALL stay in pwm_mixer.

Verification
REQ-037 Reset: hold i_rst_n low 5 clocks -> o_pwm 0, o_pwm_n 1, o_cycle_end 0; after release the first o_cycle_end occurs on clock 256.
REQ-038 Unity gain: ch0 = 128, gain 15, ch1-3 muted, top 255 -> from the second full period on, 128 high clocks then 128 low clocks, o_clip 0.
REQ-039 Gain: ch0 = 255, gain 7, others muted -> cmp 127 -> 127 high clocks per 256.
REQ-040 Saturation: all four channels = 200, gain 15 -> mix 800, cmp 256, o_pwm constantly high, o_clip 1 for the whole period.
REQ-041 Period change: i_top = 99 pulsed at counter 50 -> current period still ends at 255; following periods are 100 clocks long with the o_cycle_end spacing matching.
REQ-042 Mid-op reset: assert i_rst_n low during an o_pwm high phase -> o_pwm 0 on the next edge, and the period restarts at 256 after release.
